// File: rtl/de2_70_nios_oci_dct_ctrl.sv
// rtl/de2_70_nios_oci_dct_ctrl.sv - OCI DCT trace sequencer: arm/trigger/stop FSM, frame packer, drain register
module de2_70_nios_oci_dct_ctrl #(
   parameter int SLOT_W = 10,
   parameter int SLOTS  = 3,
   parameter int CNT_W  = 4,
   parameter int FCNT_W = 16,
   parameter int BUF_W  = SLOT_W * SLOTS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic              trig,
   input  logic              stop,
   input  logic              frm_valid,
   input  logic [SLOT_W-1:0] frm_data,
   output logic              frm_ready,
   output logic              out_valid,
   output logic [BUF_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_count,
   input  logic              out_ready,
   output logic [BUF_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic [FCNT_W-1:0] frames_captured,
   output logic              test_ending,
   output logic              test_has_ended,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      CAPTURE = 3'd2,
      FLUSH   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);

   state_t            state_q;
   state_t            state_d;
   logic              pack;
   logic              full_load;
   logic              flush_load;
   logic              arm_clear;
   logic              out_free;
   logic [BUF_W-1:0]  buf_next;

   // The output register can take a new word when it is empty or draining this cycle.
   assign out_free = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      frm_ready  = 1'b1;
      pack       = 1'b0;
      flush_load = 1'b0;
      arm_clear  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arm) begin
               state_d   = ARMED;
               arm_clear = 1'b1;
            end
         end
         ARMED: begin
            if (stop) begin
               state_d = IDLE;
            end else if (trig) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Only stall when the incoming frame would complete a word that has nowhere to go.
            frm_ready = !((dct_count == LAST_SLOT) && out_valid && !out_ready);
            pack      = frm_valid && frm_ready;
            if (stop) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            frm_ready = 1'b0;
            if (dct_count != '0) begin
               if (out_free) begin
                  flush_load = 1'b1;
                  state_d    = DONE;
               end
            end else if (!out_valid) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (arm) begin
               state_d   = ARMED;
               arm_clear = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign full_load = pack && (dct_count == LAST_SLOT);

   always_comb begin
      buf_next = dct_buffer;
      for (int k = 0; k < SLOTS; k++) begin
         if (dct_count == CNT_W'(k)) begin
            buf_next[k*SLOT_W +: SLOT_W] = frm_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_count       <= '0;
         dct_buffer      <= '0;
         dct_count       <= '0;
         frames_captured <= '0;
      end else begin
         if (full_load || flush_load) begin
            out_valid <= 1'b1;
            out_data  <= full_load ? buf_next : dct_buffer;
            out_count <= full_load ? FULL_CNT : dct_count;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // Slots above dct_count stay zero, so a flushed partial word needs no masking.
         if (full_load || flush_load) begin
            dct_buffer <= '0;
            dct_count  <= '0;
         end else if (pack) begin
            dct_buffer <= buf_next;
            dct_count  <= dct_count + CNT_W'(1);
         end

         if (arm_clear) begin
            frames_captured <= '0;
         end else if (pack && (frames_captured != {FCNT_W{1'b1}})) begin
            frames_captured <= frames_captured + FCNT_W'(1);
         end
      end
   end

   assign test_ending    = (state_q == FLUSH);
   assign test_has_ended = (state_q == DONE);
   assign state          = state_q;

endmodule

// File: tb/tb_de2_70_nios_oci_dct_ctrl.sv
// tb/tb_de2_70_nios_oci_dct_ctrl.sv - scoreboard bench for the OCI DCT trace sequencer
module tb_de2_70_nios_oci_dct_ctrl;

   localparam int SLOT_W = 10;
   localparam int SLOTS  = 3;
   localparam int CNT_W  = 4;
   localparam int FCNT_W = 16;
   localparam int BUF_W  = SLOT_W * SLOTS;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              arm, trig, stop;
   logic              frm_valid;
   logic [SLOT_W-1:0] frm_data;
   logic              frm_ready;
   logic              out_valid;
   logic [BUF_W-1:0]  out_data;
   logic [CNT_W-1:0]  out_count;
   logic              out_ready;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic [FCNT_W-1:0] frames_captured;
   logic              test_ending, test_has_ended;
   logic [2:0]        state;

   de2_70_nios_oci_dct_ctrl #(
      .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .FCNT_W(FCNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .arm(arm), .trig(trig), .stop(stop),
      .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(frm_ready),
      .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
      .out_ready(out_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .frames_captured(frames_captured), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BUF_W-1:0] data;
      logic [CNT_W-1:0] count;
   } word_t;

   word_t            sb[$];
   word_t            exp_w;
   logic [BUF_W-1:0] m_buf;
   int               m_cnt;
   int               m_fc;
   bit               m_armed;
   bit               m_cap;
   int               checks = 0;
   int               errors = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_pack(input logic [SLOT_W-1:0] d);
      m_buf[m_cnt*SLOT_W +: SLOT_W] = d;
      m_cnt++;
      m_fc++;
      if (m_cnt == SLOTS) begin
         sb.push_back({m_buf, CNT_W'(SLOTS)});
         m_buf = '0;
         m_cnt = 0;
      end
   endtask

   task automatic send_frame(input logic [SLOT_W-1:0] d);
      int n = 0;
      frm_valid = 1'b1;
      frm_data  = d;
      @(negedge clk);
      while (!frm_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!frm_ready) begin
         errors++;
         $display("FAIL frame_accept_timeout: frm_ready=%0b required 1", frm_ready);
      end else if (m_cap) begin
         model_pack(d);
      end
      @(posedge clk);
      #1;
      frm_valid = 1'b0;
   endtask

   task automatic do_arm;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      m_armed = 1'b1;
      m_fc = 0;
   endtask

   task automatic do_trig;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      if (m_armed) m_cap = 1'b1;
      m_armed = 1'b0;
   endtask

   task automatic do_stop;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      if (m_cap && m_cnt > 0) sb.push_back({m_buf, CNT_W'(m_cnt)});
      m_cap = 1'b0;
      m_buf = '0;
      m_cnt = 0;
   endtask

   task automatic wait_drain;
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d out_valid=%0b required 0 0", sb.size(), out_valid);
      end
   endtask

   // Drain-side scoreboard: every accepted word must match the oldest expected one.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: out_data=%h out_count=%0d required no word", out_data, out_count);
         end else begin
            exp_w = sb.pop_front();
            if (out_data !== exp_w.data || out_count !== exp_w.count) begin
               errors++;
               $display("FAIL drained_word: out_data=%h out_count=%0d required %h %0d",
                        out_data, out_count, exp_w.data, exp_w.count);
            end
         end
      end
   end

   task automatic test_reset;
      tick();
      checks++;
      if ({state, frm_ready, out_valid, out_data, out_count, dct_buffer, dct_count,
           frames_captured, test_ending, test_has_ended} !==
          {3'd0, 1'b1, 1'b0, 30'd0, 4'd0, 30'd0, 4'd0, 16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: state=%0d frm_ready=%0b out_valid=%0b out_data=%h dct_count=%0d fc=%0d required 0 1 0 0 0 0",
                  state, frm_ready, out_valid, out_data, dct_count, frames_captured);
      end
   endtask

   task automatic test_full_word;
      out_ready = 1'b1;
      do_arm();
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL t1_armed: state=%0d required 1", state); end
      do_trig();
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL t1_capture: state=%0d required 2", state); end
      send_frame(10'h001);
      send_frame(10'h002);
      send_frame(10'h003);
      checks++;
      if ({out_valid, out_data, out_count, dct_count, frames_captured} !==
          {1'b1, 30'h00300801, 4'd3, 4'd0, 16'd3}) begin
         errors++;
         $display("FAIL t1_word: out_valid=%0b out_data=%h out_count=%0d dct_count=%0d fc=%0d required 1 00300801 3 0 3",
                  out_valid, out_data, out_count, dct_count, frames_captured);
      end
   endtask

   task automatic test_back_to_back;
      logic [BUF_W-1:0] word_a;
      word_a = {10'h012, 10'h011, 10'h010};
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(SLOT_W'(10'h010 + i));
      checks++;
      if ({frm_ready, dct_count, out_valid, out_data} !== {1'b0, 4'd2, 1'b1, word_a}) begin
         errors++;
         $display("FAIL t2_stall: frm_ready=%0b dct_count=%0d out_valid=%0b out_data=%h required 0 2 1 %h",
                  frm_ready, dct_count, out_valid, out_data, word_a);
      end
      fork
         send_frame(10'h015);
         begin
            for (int i = 0; i < 4; i++) begin
               tick();
               checks++;
               if (out_data !== word_a || out_count !== 4'd3) begin
                  errors++;
                  $display("FAIL t2_hold: out_data=%h out_count=%0d required %h 3", out_data, out_count, word_a);
               end
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (frames_captured !== FCNT_W'(m_fc)) begin
         errors++;
         $display("FAIL t2_frames: frames_captured=%0d required %0d", frames_captured, m_fc);
      end
   endtask

   task automatic test_flush;
      do_stop();
      tick();
      checks++;
      if (state !== 3'd4 || test_has_ended !== 1'b1) begin
         errors++;
         $display("FAIL t3_empty_flush: state=%0d test_has_ended=%0b required 4 1", state, test_has_ended);
      end
      do_arm();
      checks++;
      if ({state, test_has_ended, frames_captured} !== {3'd1, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL t3_rearm: state=%0d test_has_ended=%0b fc=%0d required 1 0 0", state, test_has_ended, frames_captured);
      end
      do_trig();
      send_frame(10'h3FF);
      send_frame(10'h155);
      do_stop();
      checks++;
      if ({state, test_ending, dct_count, frm_ready} !== {3'd3, 1'b1, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL t3_flush: state=%0d test_ending=%0b dct_count=%0d frm_ready=%0b required 3 1 2 0",
                  state, test_ending, dct_count, frm_ready);
      end
      tick();
      checks++;
      if ({state, test_has_ended, test_ending, out_valid, out_data, out_count, dct_count} !==
          {3'd4, 1'b1, 1'b0, 1'b1, 30'h000557FF, 4'd2, 4'd0}) begin
         errors++;
         $display("FAIL t3_partial: state=%0d ended=%0b ending=%0b out_valid=%0b out_data=%h out_count=%0d required 4 1 0 1 000557ff 2",
                  state, test_has_ended, test_ending, out_valid, out_data, out_count);
      end
      wait_drain();
   endtask

   task automatic test_trig_stop;
      do_arm();
      send_frame(10'h0AA);
      send_frame(10'h0BB);
      trig = 1'b1; stop = 1'b1; frm_valid = 1'b1; frm_data = 10'h0CC;
      tick();
      trig = 1'b0; stop = 1'b0; frm_valid = 1'b0;
      m_armed = 1'b0;
      checks++;
      if ({state, frames_captured, dct_count, out_valid} !== {3'd0, 16'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL t4_stop_wins: state=%0d fc=%0d dct_count=%0d out_valid=%0b required 0 0 0 0",
                  state, frames_captured, dct_count, out_valid);
      end
      do_arm();
      trig = 1'b1; frm_valid = 1'b1; frm_data = 10'h0DD;
      tick();
      trig = 1'b0; frm_valid = 1'b0;
      m_armed = 1'b0; m_cap = 1'b1;
      checks++;
      if ({state, frames_captured, dct_count} !== {3'd2, 16'd0, 4'd0}) begin
         errors++;
         $display("FAIL t4_trig_frame: state=%0d fc=%0d dct_count=%0d required 2 0 0", state, frames_captured, dct_count);
      end
      do_stop();
      tick();
      checks++;
      if (state !== 3'd4 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t4_done: state=%0d out_valid=%0b required 4 0", state, out_valid);
      end
   endtask

   task automatic test_async_reset;
      do_arm();
      do_trig();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(SLOT_W'($urandom_range(0, 1023)));
      checks++;
      if (dct_count !== 4'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL t5_setup: dct_count=%0d out_valid=%0b required 2 1", dct_count, out_valid);
      end
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({state, frm_ready, out_valid, out_data, out_count, dct_buffer, dct_count,
           frames_captured, test_ending, test_has_ended} !==
          {3'd0, 1'b1, 1'b0, 30'd0, 4'd0, 30'd0, 4'd0, 16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL t5_async: state=%0d out_valid=%0b out_data=%h dct_count=%0d fc=%0d required 0 0 0 0 0",
                  state, out_valid, out_data, dct_count, frames_captured);
      end
      sb.delete();
      m_buf = '0; m_cnt = 0; m_cap = 1'b0; m_armed = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++;
      if (frm_ready !== 1'b1 || state !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t5_release: frm_ready=%0b state=%0d out_valid=%0b required 1 0 0", frm_ready, state, out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      arm = 1'b0; trig = 1'b0; stop = 1'b0;
      frm_valid = 1'b0; frm_data = '0; out_ready = 1'b0;
      m_buf = '0; m_cnt = 0; m_fc = 0; m_armed = 1'b0; m_cap = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      test_reset();
      test_full_word();
      test_back_to_back();
      test_flush();
      test_trig_stop();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
